// File: rtl/leaf_user_shell_pkg.sv
// Shared types and constants for the leaf user shell: FSM states, counter widths
// and a constant clog2 used to size FIFO pointers.
package leaf_user_shell_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DONE_CNT_BITS = 16;
    localparam int STAT_BITS     = 32;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/leaf_user_shell_if.sv
// Bundle of every stream, control and status signal between leaf_interface,
// the user shell and the HLS kernel. The shell uses the slave modport.
interface leaf_user_shell_if #(
    parameter int PB = 32,
    parameter int NI = 2,
    parameter int NO = 1
);
    import leaf_user_shell_pkg::*;

    logic                         ap_start;
    logic [NI*PB-1:0]             if_dout;
    logic [NI-1:0]                if_vld;
    logic [NI-1:0]                if_ack;
    logic [NI*PB-1:0]             usr_in_tdata;
    logic [NI-1:0]                usr_in_tvalid;
    logic [NI-1:0]                usr_in_tready;
    logic [NO*PB-1:0]             usr_out_tdata;
    logic [NO-1:0]                usr_out_tvalid;
    logic [NO-1:0]                usr_out_tready;
    logic [NO*PB-1:0]             if_din;
    logic [NO-1:0]                if_vld_out;
    logic [NO-1:0]                if_ack_in;
    logic                         kernel_ap_start;
    logic                         kernel_ap_done;
    logic                         busy;
    logic [DONE_CNT_BITS-1:0]     done_count;
    logic [(NI+NO)*STAT_BITS-1:0] stat_beats;

    modport slave (
        input  ap_start, if_dout, if_vld, usr_in_tready,
        input  usr_out_tdata, usr_out_tvalid, if_ack_in, kernel_ap_done,
        output if_ack, usr_in_tdata, usr_in_tvalid, usr_out_tready,
        output if_din, if_vld_out, kernel_ap_start, busy, done_count, stat_beats
    );

    modport master (
        output ap_start, if_dout, if_vld, usr_in_tready,
        output usr_out_tdata, usr_out_tvalid, if_ack_in, kernel_ap_done,
        input  if_ack, usr_in_tdata, usr_in_tvalid, usr_out_tready,
        input  if_din, if_vld_out, kernel_ap_start, busy, done_count, stat_beats
    );

endinterface

// File: rtl/leaf_shell_fifo.sv
// Synchronous valid/ready FIFO for one shell channel. in_ready is a register
// computed from next-state fullness, so a pop never frees a slot the same cycle.
module leaf_shell_fifo
    import leaf_user_shell_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             ready_q, ready_d;
    logic             push, pop, empty;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign push      = in_valid & ready_q;
    assign pop       = out_valid & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = !empty;
    // Zero the head word while empty so reset and idle present clean data.
    assign out_data  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        ready_d  = !((wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                     (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

endmodule

// File: rtl/leaf_user_shell.sv
// User-side shell of a leaf page: one FIFO per stream channel, ap_start FSM and
// done counter. Define LEAF_USER_SHELL_STATS_EN to build per-channel beat counters.
module leaf_user_shell
    import leaf_user_shell_pkg::*;
#(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_IN_PORTS  = 2,
    parameter int NUM_OUT_PORTS = 1,
    parameter int FIFO_DEPTH    = 4,
    parameter int AUTO_RESTART  = 0
) (
    input logic              ap_clk,
    input logic              ap_rst_n,
    leaf_user_shell_if.slave bus
);
    localparam int PB  = PAYLOAD_BITS;
    localparam int NI  = NUM_IN_PORTS;
    localparam int NO  = NUM_OUT_PORTS;
    localparam int NCH = NI + NO;

    for (genvar gi = 0; gi < NI; gi++) begin : g_in
        leaf_shell_fifo #(.WIDTH(PB), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (ap_clk),
            .rst_n     (ap_rst_n),
            .in_data   (bus.if_dout[gi*PB +: PB]),
            .in_valid  (bus.if_vld[gi]),
            .in_ready  (bus.if_ack[gi]),
            .out_data  (bus.usr_in_tdata[gi*PB +: PB]),
            .out_valid (bus.usr_in_tvalid[gi]),
            .out_ready (bus.usr_in_tready[gi])
        );
    end

    for (genvar gi = 0; gi < NO; gi++) begin : g_out
        leaf_shell_fifo #(.WIDTH(PB), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (ap_clk),
            .rst_n     (ap_rst_n),
            .in_data   (bus.usr_out_tdata[gi*PB +: PB]),
            .in_valid  (bus.usr_out_tvalid[gi]),
            .in_ready  (bus.usr_out_tready[gi]),
            .out_data  (bus.if_din[gi*PB +: PB]),
            .out_valid (bus.if_vld_out[gi]),
            .out_ready (bus.if_ack_in[gi])
        );
    end

    state_e                   state_q, state_d;
    logic [DONE_CNT_BITS-1:0] done_cnt_q, done_cnt_d;

    // A done in RUN takes priority; ap_start is only looked at in IDLE.
    always_comb begin
        state_d    = state_q;
        done_cnt_d = done_cnt_q;
        case (state_q)
            IDLE: if (bus.ap_start) state_d = RUN;
            RUN: begin
                if (bus.kernel_ap_done) begin
                    done_cnt_d = done_cnt_q + DONE_CNT_BITS'(1);
                    if (AUTO_RESTART == 0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= IDLE;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign bus.kernel_ap_start = (state_q == RUN);
    assign bus.busy            = (state_q == RUN);
    assign bus.done_count      = done_cnt_q;

`ifdef LEAF_USER_SHELL_STATS_EN
    logic [NCH-1:0] xfer;

    for (genvar gi = 0; gi < NI; gi++) begin : g_xfer_in
        assign xfer[gi] = bus.usr_in_tvalid[gi] & bus.usr_in_tready[gi];
    end
    for (genvar gi = 0; gi < NO; gi++) begin : g_xfer_out
        assign xfer[NI+gi] = bus.usr_out_tvalid[gi] & bus.usr_out_tready[gi];
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_stat
        logic [STAT_BITS-1:0] stat_q, stat_d;

        always_comb begin
            stat_d = stat_q;
            if (xfer[gi] && (stat_q != '1)) stat_d = stat_q + STAT_BITS'(1);
        end

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) stat_q <= '0;
            else           stat_q <= stat_d;
        end

        assign bus.stat_beats[gi*STAT_BITS +: STAT_BITS] = stat_q;
    end
`else
    assign bus.stat_beats = '0;
`endif

endmodule
